// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer_if
//  Description : Handshake bundle between the SIMPLE control path and the
//                phase sequencer: start/step/halt/memory-ready inputs and the
//                phase, enable and status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec;
  logic             step;
  logic             halt;
  logic             mem_access;
  logic             mem_ready;
  logic [2:0]       phase;
  logic [4:0]       ph_en;
  logic             executing;
  logic             pc_e;
  logic             bus_err;
  logic [CNT_W-1:0] instr_count;

  // Control side: drives button/decoder/memory status, observes the phases
  modport master (
    output exec, step, halt, mem_access, mem_ready,
    input  phase, ph_en, executing, pc_e, bus_err, instr_count
  );

  // Sequencer side
  modport slave (
    input  exec, step, halt, mem_access, mem_ready,
    output phase, ph_en, executing, pc_e, bus_err, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Five-phase instruction-cycle controller for the SIMPLE
//                16-bit processor. Start/stop from the exec button, single
//                step, HLT, P4 memory stall with timeout, retired counter.
//  Revision    : 1.0  initial release
// ============================================================================
module phase_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  phase_sequencer_if.slave  sif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_P4   = 3'd4,
    ST_P5   = 3'd5
  } phase_t;

  // Stall counter is sized for the largest legal WAIT_MAX (255)
  localparam logic [7:0] c_wait_max = 8'(WAIT_MAX);

  phase_t           phase_q,       phase_d;
  logic             stop_req_q,    stop_req_d;
  logic [7:0]       wait_cnt_q,    wait_cnt_d;
  logic             exec_prev_q,   exec_prev_d;
  logic             bus_err_q,     bus_err_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [4:0]       ph_en_q,       ph_en_d;
  logic             pc_e_q,        pc_e_d;
  logic             executing_q,   executing_d;

  logic             exec_rise;

  // A held button yields a single rise
  assign exec_rise = sif.exec & ~exec_prev_q;

  // Next-state logic for the phase machine, stall counter and status flags
  always_comb begin
    phase_d       = phase_q;
    stop_req_d    = stop_req_q;
    wait_cnt_d    = wait_cnt_q;
    bus_err_d     = bus_err_q;
    instr_count_d = instr_count_q;
    exec_prev_d   = sif.exec;

    // A press while running asks to stop at the end of the current instruction
    if ((phase_q != ST_IDLE) && exec_rise) begin
      stop_req_d = 1'b1;
    end

    case (phase_q)
      ST_IDLE: begin
        if (exec_rise) begin
          phase_d    = ST_P1;
          stop_req_d = 1'b0;
          bus_err_d  = 1'b0;
          wait_cnt_d = 8'd0;
        end
      end
      ST_P1: phase_d = ST_P2;
      ST_P2: phase_d = ST_P3;
      ST_P3: phase_d = ST_P4;
      ST_P4: begin
        if (!sif.mem_access || sif.mem_ready) begin
          phase_d    = ST_P5;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == c_wait_max) begin
          // Memory never answered: abandon the instruction without retiring it
          phase_d    = ST_IDLE;
          bus_err_d  = 1'b1;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_P5: begin
        instr_count_d = instr_count_q + 1'b1;
        // A press landing in P5 stops after this instruction, never restarts
        if (stop_req_q || exec_rise || sif.halt || sif.step) begin
          phase_d = ST_IDLE;
        end else begin
          phase_d = ST_P1;
        end
      end
      default: phase_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next phase so they register alongside it
    executing_d = (phase_d != ST_IDLE);
    pc_e_d      = (phase_d == ST_P5);
    case (phase_d)
      ST_P1:   ph_en_d = 5'b00001;
      ST_P2:   ph_en_d = 5'b00010;
      ST_P3:   ph_en_d = 5'b00100;
      ST_P4:   ph_en_d = 5'b01000;
      ST_P5:   ph_en_d = 5'b10000;
      default: ph_en_d = 5'b00000;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q       <= ST_IDLE;
      stop_req_q    <= 1'b0;
      wait_cnt_q    <= 8'd0;
      exec_prev_q   <= 1'b0;
      bus_err_q     <= 1'b0;
      instr_count_q <= '0;
      ph_en_q       <= 5'b00000;
      pc_e_q        <= 1'b0;
      executing_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      stop_req_q    <= stop_req_d;
      wait_cnt_q    <= wait_cnt_d;
      exec_prev_q   <= exec_prev_d;
      bus_err_q     <= bus_err_d;
      instr_count_q <= instr_count_d;
      ph_en_q       <= ph_en_d;
      pc_e_q        <= pc_e_d;
      executing_q   <= executing_d;
    end
  end

  assign sif.phase       = phase_q;
  assign sif.ph_en       = ph_en_q;
  assign sif.executing   = executing_q;
  assign sif.pc_e        = pc_e_q;
  assign sif.bus_err     = bus_err_q;
  assign sif.instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Central phase controller for the SIMPLE 16-bit processor.
- Owns the 5-phase instruction cycle: P1 fetch, P2 decode/read, P3 execute, P4 memory, P5 writeback/PC update.
- Starts and stops execution from the exec button, single-steps, halts on decoded HLT, stalls P4 on slow data memory, and counts retired instructions.
- Its outputs gate the register/PC enables produced by the control decoder.

Parameters:
WAIT_MAX, 15, max consecutive P4 stall cycles before a bus error (1..255).
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-low reset; rst=0 at a clk edge resets all state.
exec  input  1  run/stop button level; may stay high for many cycles.
step  input  1  single-step mode level; sampled in P5.
halt  input  1  decoded HLT instruction; sampled in P5.
mem_access  input  1  current instruction uses data memory in P4.
mem_ready  input  1  data memory completes the access this cycle.
phase  output  3  0=IDLE, 1..5 = P1..P5.
ph_en  output  5  one-hot phase enable; bit k-1 high in Pk, 0 in IDLE.
executing  output  1  high while the sequencer is out of IDLE.
pc_e  output  1  PC update enable; high exactly in P5.
bus_err  output  1  sticky P4 timeout flag.
instr_count  output  CNT_W  number of instructions retired (P5 completions), wraps.

Behaviour:
Reset (rst=0 at edge):
- phase=0, executing=0, bus_err=0, instr_count=0.
- stop_req=0, wait_cnt=0, exec_d=0.
- Applies from any phase, including mid-stall; no partial completion.

Edge detect:
- exec_d registers exec.
- exec_rise = exec & ~exec_d.
- A held button produces exactly one rise.

Output decoding:
- phase, ph_en, pc_e and executing decode from the phase register (Moore; no combinational input-to-output path).
- executing = (phase != 0).

IDLE:
- On exec_rise: next phase=1, stop_req=0, bus_err=0, wait_cnt=0.
- Otherwise stay in IDLE.

P1 -> P2 -> P3 -> P4: one cycle each, unconditional.

Stop request:
- In any phase 1..5, exec_rise sets stop_req=1.
- stop_req is cleared only in IDLE start or by reset.

P4:
- If mem_access=0 or mem_ready=1: next phase=5, wait_cnt=0.
- Else stay in P4 and increment wait_cnt.
- If stalled with wait_cnt==WAIT_MAX: next phase=0, bus_err=1, wait_cnt=0, instruction not retired.
- P4 therefore lasts at most WAIT_MAX+1 cycles.

P5:
- Always retires: instr_count += 1, modulo 2^CNT_W.
- If stop_req | exec_rise | halt | step: next phase=0.
- Else next phase=1.
- exec_rise coinciding with P5 stops after this instruction; it does not restart.

Latency:
- Unstalled instruction = 5 cycles.
- First P1 follows the exec_rise edge by one cycle.

Simultaneous events:
- Reset dominates all other events.
- P4 timeout dominates stop_req (stop_req is cleared on the next start).
- halt and step are ignored outside P5.

Test Plan:
- Reset then exec held high for 20 cycles, step=0, halt=0, mem_access=0 → phase 1,2,3,4,5,1,... continuously.
  - One rise only, so execution does not stop.
  - instr_count=3 after 15 cycles in P1..P5.
  - pc_e high exactly on phase=5 cycles.
- While running, pulse exec low→high during P2 → current instruction finishes P5, phase=0, executing=0 next cycle, instr_count incremented once.
- step=1, exec rise from IDLE → exactly one pass P1..P5, then IDLE, instr_count+1.
  - Second exec rise → one more instruction.
- mem_access=1, mem_ready rises after 3 stall cycles → P4 lasts 4 cycles, then P5.
  - mem_ready never rises with WAIT_MAX=15 → P4 lasts 16 cycles, then phase=0, bus_err=1, instr_count unchanged.
  - Next exec rise clears bus_err.
- halt=1 presented in P3 only → ignored, execution continues.
  - halt=1 in P5 → IDLE next cycle.
- rst=0 during P4 stall with instr_count=0x00FF → next cycle phase=0, instr_count=0, bus_err=0.
  - instr_count preset near 0xFFFF via 65535 retires (or forced) → wraps to 0x0000 on the next P5.
